// File: rtl/sensor_conditioner.sv
// -----------------------------------------------------------------------------
// sensor_conditioner
//
// Front end for the traffic-light controller. The four raw vehicle sensors
// (AS1, AS2 on the main road; BS1, BS2 on the side road) are synchronised and
// debounced. Each road then gets a presence flag that stays up for HOLD_CYCLES
// after its last sensor drops. The block also keeps a saturating vehicle
// counter per road.
//
// There is no handshake. Every output is a plain registered or combinational
// level, valid on every cycle, and the block never stalls.
//
// Ports
//   clk_50M       in   1      system clock
//   reset_btn     in   1      asynchronous active-low reset
//   AS1, AS2      in   1      raw main-road sensors (asynchronous, active-high)
//   BS1, BS2      in   1      raw side-road sensors (asynchronous, active-high)
//   clear_cnt     in   1      synchronous clear of both vehicle counters
//   sensor_combo  out  2      {main present, side present}
//   combo_change  out  1      one-cycle pulse on the first cycle of a new combo
//   db_sensors    out  4      debounced {AS1, AS2, BS1, BS2}
//   veh_cnt_a     out  CNT_W  saturating main-road vehicle count
//   veh_cnt_b     out  CNT_W  saturating side-road vehicle count
// -----------------------------------------------------------------------------
module sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 100000000,
    parameter int CNT_W           = 8
) (
    input  logic             clk_50M,
    input  logic             reset_btn,
    input  logic             AS1,
    input  logic             AS2,
    input  logic             BS1,
    input  logic             BS2,
    input  logic             clear_cnt,
    output logic [1:0]       sensor_combo,
    output logic             combo_change,
    output logic [3:0]       db_sensors,
    output logic [CNT_W-1:0] veh_cnt_a,
    output logic [CNT_W-1:0] veh_cnt_b
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    // With HOLD_CYCLES = 0 the hold counter is never loaded with a non-zero
    // value. It still needs at least one bit so that it is a legal vector.
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Bit order everywhere: [3]=AS1 [2]=AS2 [1]=BS1 [0]=BS2
    logic [3:0]        w_raw;
    logic [3:0]        r_s1;
    logic [3:0]        r_s2;
    logic [3:0]        r_db;
    logic [3:0]        r_db_d;
    logic [DB_W-1:0]   r_db_cnt [4];

    // Road index: [1]=main (A), [0]=side (B)
    logic [1:0]        w_road_raw;
    logic [HOLD_W-1:0] r_hold [2];
    logic [1:0]        r_present;
    logic [1:0]        r_combo_prev;

    logic [3:0]        w_rise;
    logic [1:0]        w_inc_a;
    logic [1:0]        w_inc_b;
    logic [CNT_W:0]    w_sum_a;
    logic [CNT_W:0]    w_sum_b;
    logic [CNT_W-1:0]  r_cnt_a;
    logic [CNT_W-1:0]  r_cnt_b;

    assign w_raw = {AS1, AS2, BS1, BS2};

    // -------------------------------------------------------------------------
    // Two-flop synchroniser
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce. The counter only runs while the synchronised level disagrees
    // with the debounced level. It restarts whenever the two agree again, so
    // a glitch shorter than DEBOUNCE_CYCLES leaves no trace behind.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            r_db <= '0;
            for (int i = 0; i < 4; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_s2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_s2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Presence hold per road. Raw presence reloads the counter, so a short gap
    // between vehicles never drops the presence flag.
    // -------------------------------------------------------------------------
    assign w_road_raw = {r_db[3] | r_db[2], r_db[1] | r_db[0]};

    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            r_present <= '0;
            for (int r = 0; r < 2; r++) begin
                r_hold[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (w_road_raw[r]) begin
                    r_hold[r]    <= HOLD_LOAD;
                    r_present[r] <= 1'b1;
                end else if (r_hold[r] != '0) begin
                    r_hold[r]    <= r_hold[r] - HOLD_W'(1);
                    r_present[r] <= 1'b1;
                end else begin
                    r_present[r] <= 1'b0;
                end
            end
        end
    end

    // The previous combo is registered and sensor_combo itself is registered.
    // The comparison is therefore true only on the first cycle of a new value.
    // A change in both bits yields a single pulse.
    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            r_combo_prev <= '0;
        end else begin
            r_combo_prev <= r_present;
        end
    end

    // -------------------------------------------------------------------------
    // Vehicle counters: count debounced rising edges and saturate at the top.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            r_db_d <= '0;
        end else begin
            r_db_d <= r_db;
        end
    end

    assign w_rise  = r_db & ~r_db_d;
    assign w_inc_a = {1'b0, w_rise[3]} + {1'b0, w_rise[2]};
    assign w_inc_b = {1'b0, w_rise[1]} + {1'b0, w_rise[0]};
    // One extra bit catches the carry that signals saturation.
    assign w_sum_a = {1'b0, r_cnt_a} + (CNT_W + 1)'(w_inc_a);
    assign w_sum_b = {1'b0, r_cnt_b} + (CNT_W + 1)'(w_inc_b);

    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else if (clear_cnt) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            r_cnt_a <= w_sum_a[CNT_W] ? CNT_MAX : w_sum_a[CNT_W-1:0];
            r_cnt_b <= w_sum_b[CNT_W] ? CNT_MAX : w_sum_b[CNT_W-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign sensor_combo = r_present;
    assign combo_change = (r_present != r_combo_prev);
    assign db_sensors   = r_db;
    assign veh_cnt_a    = r_cnt_a;
    assign veh_cnt_b    = r_cnt_b;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed testbench for sensor_conditioner with DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=8 and CNT_W=8. Inputs change 1 ns after a rising edge.
// Outputs are sampled 1 ns after the edge under test, and edge counts are
// relative to the input change.
module tb_sensor_conditioner;

    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int CW   = 8;

    logic          clk_50M;
    logic          reset_btn;
    logic          AS1, AS2, BS1, BS2;
    logic          clear_cnt;
    logic [1:0]    sensor_combo;
    logic          combo_change;
    logic [3:0]    db_sensors;
    logic [CW-1:0] veh_cnt_a;
    logic [CW-1:0] veh_cnt_b;

    int n_checks;
    int n_pass;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD),
        .CNT_W          (CW)
    ) dut (
        .clk_50M     (clk_50M),
        .reset_btn   (reset_btn),
        .AS1         (AS1),
        .AS2         (AS2),
        .BS1         (BS1),
        .BS2         (BS2),
        .clear_cnt   (clear_cnt),
        .sensor_combo(sensor_combo),
        .combo_change(combo_change),
        .db_sensors  (db_sensors),
        .veh_cnt_a   (veh_cnt_a),
        .veh_cnt_b   (veh_cnt_b)
    );

    // ---------------- clock ----------------
    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_sensors(input logic [3:0] v);
        {AS1, AS2, BS1, BS2} = v;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_pass    = 0;
        clear_cnt = 1'b0;
        set_sensors(4'b1111);
        reset_btn = 1'b1;
        #5 reset_btn = 1'b0;

        // Reset with all sensors high: every output is held at zero.
        wait_cycles(3);
        check("rst_combo",  32'(sensor_combo), 32'd0);
        check("rst_change", 32'(combo_change), 32'd0);
        check("rst_db",     32'(db_sensors),   32'd0);
        check("rst_cnt_a",  32'(veh_cnt_a),    32'd0);
        check("rst_cnt_b",  32'(veh_cnt_b),    32'd0);

        // Release the reset with only AS1 high. The full debounce latency
        // applies again, and one vehicle is counted.
        set_sensors(4'b1000);
        reset_btn = 1'b1;
        wait_cycles(5);
        check("rel_db_e5", 32'(db_sensors), 32'd0);
        step();
        check("rel_db_e6",    32'(db_sensors),   32'b1000);
        check("rel_combo_e6", 32'(sensor_combo), 32'd0);
        step();
        check("rel_combo_e7",  32'(sensor_combo), 32'b10);
        check("rel_change_e7", 32'(combo_change), 32'd1);
        check("rel_cnt_a_e7",  32'(veh_cnt_a),    32'd1);
        step();
        check("rel_change_e8", 32'(combo_change), 32'd0);

        // AS1 drops: db falls at edge 6 and presence falls 9 edges later.
        set_sensors(4'b0000);
        wait_cycles(5);
        check("dropa_db_e5", 32'(db_sensors), 32'b1000);
        step();
        check("dropa_db_e6", 32'(db_sensors), 32'd0);
        wait_cycles(8);
        check("dropa_combo_e14", 32'(sensor_combo), 32'b10);
        step();
        check("dropa_combo_e15",  32'(sensor_combo), 32'b00);
        check("dropa_change_e15", 32'(combo_change), 32'd1);
        step();

        // 3-cycle glitch on AS1 is rejected.
        set_sensors(4'b1000);
        wait_cycles(3);
        set_sensors(4'b0000);
        wait_cycles(12);
        check("glitch_db",    32'(db_sensors),   32'd0);
        check("glitch_combo", 32'(sensor_combo), 32'd0);
        check("glitch_cnt_a", 32'(veh_cnt_a),    32'd1);

        // AS1 held for 10 cycles.
        set_sensors(4'b1000);
        wait_cycles(5);
        check("held_db_e5", 32'(db_sensors), 32'd0);
        step();
        check("held_db_e6",     32'(db_sensors),   32'b1000);
        check("held_change_e6", 32'(combo_change), 32'd0);
        step();
        check("held_combo_e7",  32'(sensor_combo), 32'b10);
        check("held_change_e7", 32'(combo_change), 32'd1);
        check("held_cnt_a_e7",  32'(veh_cnt_a),    32'd2);
        step();
        check("held_change_e8", 32'(combo_change), 32'd0);
        wait_cycles(2);
        set_sensors(4'b0000);
        wait_cycles(20);
        check("held_combo_end", 32'(sensor_combo), 32'd0);

        // Side-road hold: BS1 rises, then falls.
        set_sensors(4'b0010);
        wait_cycles(6);
        check("holdb_db_e6", 32'(db_sensors), 32'b0010);
        step();
        check("holdb_combo_e7", 32'(sensor_combo), 32'b01);
        check("holdb_cnt_b_e7", 32'(veh_cnt_b),    32'd1);
        set_sensors(4'b0000);
        wait_cycles(6);
        check("holdb_dbfall_e6", 32'(db_sensors), 32'd0);
        wait_cycles(8);
        check("holdb_combo_e14", 32'(sensor_combo), 32'b01);
        step();
        check("holdb_combo_e15",  32'(sensor_combo), 32'b00);
        check("holdb_change_e15", 32'(combo_change), 32'd1);

        // BS1 re-asserted during the hold: presence never drops.
        set_sensors(4'b0010);
        wait_cycles(7);
        check("reass_combo_up", 32'(sensor_combo), 32'b01);
        check("reass_cnt_b_1",  32'(veh_cnt_b),    32'd2);
        set_sensors(4'b0000);
        wait_cycles(6);
        check("reass_dbfall", 32'(db_sensors), 32'd0);
        set_sensors(4'b0010);
        for (int k = 0; k < 15; k++) begin
            step();
            check("reass_combo_held", 32'(sensor_combo), 32'b01);
        end
        check("reass_cnt_b_2", 32'(veh_cnt_b), 32'd3);
        set_sensors(4'b0000);
        wait_cycles(20);
        check("reass_combo_end", 32'(sensor_combo), 32'd0);

        // AS1 and AS2 rise on the same edge: count +2.
        set_sensors(4'b1100);
        wait_cycles(6);
        check("simA_db", 32'(db_sensors), 32'b1100);
        step();
        check("simA_cnt_a", 32'(veh_cnt_a),    32'd4);
        check("simA_combo", 32'(sensor_combo), 32'b10);
        set_sensors(4'b0000);
        wait_cycles(20);
        check("simA_combo_end", 32'(sensor_combo), 32'd0);

        // All four sensors rise together: 00 -> 11 with a single pulse.
        set_sensors(4'b1111);
        wait_cycles(6);
        check("all_db_e6",     32'(db_sensors),   32'b1111);
        check("all_change_e6", 32'(combo_change), 32'd0);
        step();
        check("all_combo_e7",  32'(sensor_combo), 32'b11);
        check("all_change_e7", 32'(combo_change), 32'd1);
        check("all_cnt_a",     32'(veh_cnt_a),    32'd6);
        check("all_cnt_b",     32'(veh_cnt_b),    32'd5);
        step();
        check("all_change_e8", 32'(combo_change), 32'd0);
        set_sensors(4'b0000);
        wait_cycles(20);
        check("all_combo_end", 32'(sensor_combo), 32'd0);

        // 260 clean AS1 pulses: the counter saturates at 255.
        for (int p = 0; p < 260; p++) begin
            set_sensors(4'b1000);
            wait_cycles(6);
            set_sensors(4'b0000);
            wait_cycles(6);
        end
        wait_cycles(15);
        check("sat_cnt_a", 32'(veh_cnt_a),    32'd255);
        check("sat_combo", 32'(sensor_combo), 32'd0);

        // clear_cnt on the same edge as an increment wins.
        set_sensors(4'b1000);
        wait_cycles(6);
        check("clr_db", 32'(db_sensors), 32'b1000);
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        check("clr_cnt_a", 32'(veh_cnt_a), 32'd0);
        check("clr_cnt_b", 32'(veh_cnt_b), 32'd0);
        wait_cycles(3);
        check("clr_cnt_a_stay", 32'(veh_cnt_a), 32'd0);
        set_sensors(4'b0000);
        wait_cycles(8);
        set_sensors(4'b1000);
        wait_cycles(7);
        check("clr_cnt_a_next", 32'(veh_cnt_a), 32'd1);
        set_sensors(4'b0000);
        wait_cycles(20);
        check("clr_combo_end", 32'(sensor_combo), 32'd0);

        // Reset in the middle of a side-road hold.
        set_sensors(4'b0010);
        wait_cycles(7);
        check("rmh_combo_up", 32'(sensor_combo), 32'b01);
        check("rmh_cnt_b",    32'(veh_cnt_b),    32'd1);
        set_sensors(4'b0000);
        wait_cycles(8);
        check("rmh_in_hold", 32'(sensor_combo), 32'b01);
        reset_btn = 1'b0;
        #2;
        check("rmh_combo_async", 32'(sensor_combo), 32'd0);
        check("rmh_change",      32'(combo_change), 32'd0);
        check("rmh_cnt_b_clr",   32'(veh_cnt_b),    32'd0);
        wait_cycles(2);
        reset_btn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rmh_post_change", 32'(combo_change), 32'd0);
            check("rmh_post_combo",  32'(sensor_combo), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Upstream front end for the traffic-light controller. It synchronises and debounces the four vehicle sensors (AS1, AS2 on the main road; BS1, BS2 on the side road) and applies a gap-tolerant presence hold per road. It delivers the 2-bit `sensor_combo` consumed by the controller's state machine, and per-road vehicle counters for the LCD sensor-status field.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a debounced sensor changes (≥1).
- `HOLD_CYCLES`, default 100000000: cycles a road's presence is held after its last sensor drops (≥0).
- `CNT_W`, default 8: vehicle counter width.

Ports:
- `clk_50M`  in  1  system clock, 50 MHz.
- `reset_btn`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `AS1`, `AS2`  in  1 each  raw main-road sensors, asynchronous, active-high.
- `BS1`, `BS2`  in  1 each  raw side-road sensors, asynchronous, active-high.
- `clear_cnt`  in  1  synchronous clear of both vehicle counters.
- `sensor_combo`  out  2  [1] = main road present, [0] = side road present.
- `combo_change`  out  1  one-cycle pulse that coincides with the first cycle of a new `sensor_combo` value.
- `db_sensors`  out  4  debounced {AS1, AS2, BS1, BS2}.
- `veh_cnt_a`  out  CNT_W  saturating count of debounced rising edges, main road.
- `veh_cnt_b`  out  CNT_W  saturating count of debounced rising edges, side road.

## Operation
- **Synchroniser.** Each raw input passes through a 2-flop synchroniser (s1 → s2).
- **Debounce.** There is one counter per sensor, of width clog2(DEBOUNCE_CYCLES)+1.
  - If s2 == db: counter ← 0.
  - Else if counter == DEBOUNCE_CYCLES−1: db ← s2 and counter ← 0.
  - Else: counter ← counter+1.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles is fully rejected, and the counter restarts from 0.
- **Road raw presence.** rawA = dbAS1 | dbAS2; rawB = dbBS1 | dbBS2.
- **Presence hold.** Each road has a hold counter (width clog2(HOLD_CYCLES+1)) and a present flag.
  - If raw: hold ← HOLD_CYCLES and present ← 1.
  - Else if hold ≠ 0: hold ← hold−1 and present ← 1.
  - Else: present ← 0.
  - Re-assertion of raw during the hold reloads the counter, so presence never drops.
- **Outputs.** sensor_combo = {presentA, presentB}. A registered copy of the previous value drives combo_change = (sensor_combo ≠ prev).
- **Vehicle counters.**
  - Each road's counter increments once for each of its sensors whose db rose this cycle. A rise on both sensors in the same cycle adds 2.
  - Counters saturate at 2^CNT_W−1; no wrap.
  - clear_cnt sets the counter to 0 and takes priority over a simultaneous increment.
- **Reset.** While `reset_btn` = 0, all flops clear asynchronously. The sensor_combo state-space behaviour for each combo value (00, 01, 10, 11) belongs to the controller; this block only reports presence.

## Timing
- **Reset values.** All outputs are 0: sensor_combo=00, combo_change=0, db_sensors=0000, veh_cnt_a=veh_cnt_b=0. All internal counters are also 0.
- **Debounce latency.** A raw pin change, held stable, appears on db at rising edge DEBOUNCE_CYCLES+2 after the change, where the first edge sampling the new level is edge 1.
- **Presence rise.** presentX rises 1 edge after the db rise, i.e. DEBOUNCE_CYCLES+3 edges after the pin.
- **Presence fall.** presentX falls HOLD_CYCLES+1 edges after the last db of that road falls. With HOLD_CYCLES=0 it follows raw with 1 cycle of latency.
- **combo_change.** High exactly 1 cycle, in the same cycle sensor_combo first shows the new value. If both bits change on the same edge, only one pulse is produced.
- **Counter latency.** veh_cnt updates 1 edge after the db rising edge.
- **Reset mid-operation.** Debounce, hold and counter state is discarded. After reset release with inputs held high, the full DEBOUNCE_CYCLES+2 latency applies again, and a count of 1 is then recorded per high sensor.
- **Throughput.** No stalls or back-pressure; all outputs are valid every cycle.

## Test plan
Run with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, CNT_W=8, 20 ns clock.
- **Reset.** Assert reset_btn=0 with all sensors high → all outputs 0. Release reset → dbAS1 rises 6 edges after release, sensor_combo=10 at edge 7, veh_cnt_a=1.
- **Glitch rejection.** AS1 pulses for 3 cycles → db_sensors, sensor_combo and veh_cnt_a are unchanged. AS1 held for 10 cycles → dbAS1 rises at edge 6 and combo_change pulses once at edge 7.
- **Hold.** BS1 high then low → sensor_combo[0] falls 9 edges after dbBS1 falls. BS1 re-asserted during the hold (gap < HOLD_CYCLES) → sensor_combo[0] stays 1 throughout and veh_cnt_b increments by 1.
- **Simultaneous.** AS1 and AS2 rise on the same edge → veh_cnt_a += 2. AS and BS rise together → sensor_combo goes 00→11 with a single combo_change pulse.
- **Saturation and clear.** 260 clean AS1 pulses → veh_cnt_a=255. clear_cnt asserted in the same cycle as an increment → veh_cnt_a=0.
- **Reset mid-hold.** Pull reset_btn low during a side-road hold → sensor_combo=00 immediately (asynchronous), with no combo_change pulse on release.
